// File: rtl/id_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the IF/ID stage.
// The stage sits on the slave modport; the fetch/execute environment uses master.
interface id_decode_stage_if #(
    parameter int PC_W = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      out_extOP;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_extOP,
               out_rs1, out_rs2, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_extOP,
               out_rs1, out_rs2, out_rd, out_illegal
    );
endinterface

// File: rtl/id_decode_stage.sv
// IF/ID stage of the RV64I core: 2-entry skid buffer with the immediate-format
// decode done on entry, so everything presented to execute comes straight from flops.
module id_decode_stage #(
    parameter int PC_W = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    id_decode_stage_if.slave   bus
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [2:0]      extop;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, extop: 3'b111, illegal: 1'b0};

    // Returns {illegal, extOP}
    function automatic logic [3:0] decode(input logic [6:0] opc, input logic [2:0] f3);
        logic [3:0] res;
        res = 4'b1111;
        case (opc)
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: res = 4'b0000;
            7'b0010011, 7'b0011011:
                res = (f3 == 3'b001 || f3 == 3'b101) ? 4'b0101 : 4'b0000;
            7'b0110111, 7'b0010111:                         res = 4'b0001;
            7'b0100011:                                     res = 4'b0010;
            7'b1100011:                                     res = 4'b0011;
            7'b1101111:                                     res = 4'b0100;
            7'b0110011, 7'b0111011:                         res = 4'b0111;
            default:                                        res = 4'b1111;
        endcase
        return res;
    endfunction

    entry_t main_reg, main_next;
    entry_t skid_reg, skid_next;
    logic   main_valid_reg, main_valid_next;
    logic   skid_valid_reg, skid_valid_next;
    entry_t in_entry;
    logic   accept;
    logic   pop;

    always_comb begin
        in_entry       = ENTRY_RST;
        in_entry.instr = bus.in_instr;
        in_entry.pc    = bus.in_pc;
        {in_entry.illegal, in_entry.extop} = decode(bus.in_instr[6:0], bus.in_instr[14:12]);
    end

    assign bus.in_ready = !skid_valid_reg && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign pop          = main_valid_reg && bus.out_ready;

    always_comb begin
        main_next       = main_reg;
        skid_next       = skid_reg;
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (!main_valid_reg || pop) begin
            if (skid_valid_reg) begin
                // The older overflow word must leave before the new one
                main_next       = skid_reg;
                main_valid_next = 1'b1;
                skid_valid_next = accept;
                if (accept) begin
                    skid_next = in_entry;
                end
            end else begin
                main_valid_next = accept;
                if (accept) begin
                    main_next = in_entry;
                end
            end
        end else if (accept) begin
            skid_next       = in_entry;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_reg       <= ENTRY_RST;
            skid_reg       <= ENTRY_RST;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign bus.out_valid   = main_valid_reg;
    assign bus.out_instr   = main_reg.instr;
    assign bus.out_pc      = main_reg.pc;
    assign bus.out_extOP   = main_reg.extop;
    assign bus.out_illegal = main_reg.illegal;
    assign bus.out_rs1     = main_reg.instr[19:15];
    assign bus.out_rs2     = main_reg.instr[24:20];
    assign bus.out_rd      = main_reg.instr[11:7];
endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: accepted words queue their hand-decoded
// response, and a negedge monitor checks every word the stage hands to execute.
module tb_id_decode_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t v;
        int   cyc;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    vec_t cur_exp;
    vec_t tbl[15];
    sb_t  q[$];

    id_decode_stage_if #(.PC_W(64)) bus ();

    id_decode_stage #(.PC_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vec_t mk(input logic [31:0] i, input logic [63:0] p, input logic [2:0] e,
                                input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                input logic il);
        vec_t v;
        v.instr = i; v.pc = p; v.ext = e; v.rs1 = s1; v.rs2 = s2; v.rd = d; v.ill = il;
        return v;
    endfunction

    function automatic vec_t at_pc(input vec_t v, input logic [63:0] p);
        vec_t r;
        r = v;
        r.pc = p;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t dut_out();
        return {bus.out_instr, bus.out_pc, bus.out_extOP, bus.out_rs1, bus.out_rs2,
                bus.out_rd, bus.out_illegal};
    endfunction

    // Monitor: check pops and stalls against the queue head, then record new accepts
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {64'b0, dut_out()}, 128'b0);
            end else if (bus.out_ready) begin
                sb_t e;
                e = q.pop_front();
                chk("pop_data", dut_out(), e.v);
                if (lat_chk) chk("latency", cyc - e.cyc, 1);
                $display("pop  pc=%0h instr=%h extOP=%b ill=%b", bus.out_pc, bus.out_instr,
                         bus.out_extOP, bus.out_illegal);
            end else begin
                chk("stall_hold", dut_out(), q[0].v);
            end
        end
        if (reset || flush) begin
            q.delete();
        end else if (bus.in_valid && bus.in_ready) begin
            sb_t n;
            n.v = cur_exp;
            n.cyc = cyc;
            q.push_back(n);
        end
    end

    // Present one word and hold it until accepted (bounded)
    task automatic drive(input vec_t v, input bit must_now);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = v.instr;
        bus.in_pc    = v.pc;
        cur_exp      = v;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (must_now && n == 0) chk("in_ready_stream", {127'b0, acc}, 128'd1);
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", 128'd0, 128'd1);
        $display("send pc=%0h instr=%h", v.pc, v.instr);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tbl[0]  = mk(32'h00500093, 64'h00, 3'b000, 5'd0, 5'd5, 5'd1, 1'b0); // addi
        tbl[1]  = mk(32'h123450B7, 64'h04, 3'b001, 5'd8, 5'd3, 5'd1, 1'b0); // lui
        tbl[2]  = mk(32'h00112023, 64'h08, 3'b010, 5'd2, 5'd1, 5'd0, 1'b0); // sw
        tbl[3]  = mk(32'h008000EF, 64'h0C, 3'b100, 5'd0, 5'd8, 5'd1, 1'b0); // jal
        tbl[4]  = mk(32'h4030D093, 64'h10, 3'b101, 5'd1, 5'd3, 5'd1, 1'b0); // srai
        tbl[5]  = mk(32'h0010809B, 64'h14, 3'b000, 5'd1, 5'd1, 5'd1, 1'b0); // addiw
        tbl[6]  = mk(32'h0000007F, 64'h18, 3'b111, 5'd0, 5'd0, 5'd0, 1'b1); // illegal
        tbl[7]  = mk(32'h00012183, 64'h1C, 3'b000, 5'd2, 5'd0, 5'd3, 1'b0); // lw
        tbl[8]  = mk(32'h000080E7, 64'h20, 3'b000, 5'd1, 5'd0, 5'd1, 1'b0); // jalr
        tbl[9]  = mk(32'h00000097, 64'h24, 3'b001, 5'd0, 5'd0, 5'd1, 1'b0); // auipc
        tbl[10] = mk(32'h00000073, 64'h28, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0); // ecall
        tbl[11] = mk(32'h0000000F, 64'h2C, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0); // fence
        tbl[12] = mk(32'h002081BB, 64'h30, 3'b111, 5'd1, 5'd2, 5'd3, 1'b0); // addw
        tbl[13] = mk(32'h00208463, 64'h100, 3'b011, 5'd1, 5'd2, 5'd8, 1'b0); // beq
        tbl[14] = mk(32'h002081B3, 64'h104, 3'b111, 5'd1, 5'd2, 5'd3, 1'b0); // add

        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.out_ready = 1'b0;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("rst_out_data", {64'b0, dut_out()}, {64'b0, mk(32'h0, 64'h0, 3'b111, 5'd0, 5'd0, 5'd0, 1'b0)});
        chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1;

        // Streaming with one-cycle latency, plus the decode table
        bus.out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 13; i++) drive(tbl[i], 1'b1);
        idle(3);
        lat_chk = 1'b0;

        // Backpressure: beq in main, add in skid
        bus.out_ready = 1'b0;
        drive(tbl[13], 1'b1);
        drive(tbl[14], 1'b1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_full", {127'b0, bus.in_ready}, 128'd0);
        chk("bp_main_extop", {125'b0, bus.out_extOP}, 128'd3);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_in_ready_back", {127'b0, bus.in_ready}, 128'd1);
        chk("bp_add_extop", {125'b0, bus.out_extOP}, 128'd7);
        @(posedge clk);
        #1 idle(2);

        // Flush with both entries full and a word offered during the flush
        bus.out_ready = 1'b0;
        drive(at_pc(tbl[0], 64'h200), 1'b0);
        drive(at_pc(tbl[1], 64'h204), 1'b0);
        bus.in_valid = 1'b1;
        bus.in_instr = tbl[2].instr;
        bus.in_pc = 64'h208;
        cur_exp = at_pc(tbl[2], 64'h208);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {127'b0, bus.in_ready}, 128'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {127'b0, bus.out_valid}, 128'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drive(at_pc(tbl[3], 64'h20C), 1'b1);
        idle(3);

        // Pop with skid full while a new word waits
        bus.out_ready = 1'b0;
        drive(at_pc(tbl[4], 64'h300), 1'b0);
        drive(at_pc(tbl[5], 64'h304), 1'b0);
        bus.out_ready = 1'b1;
        drive(at_pc(tbl[6], 64'h308), 1'b0);
        drive(at_pc(tbl[7], 64'h30C), 1'b0);
        idle(4);

        // Reset in the middle of a stall
        bus.out_ready = 1'b0;
        drive(at_pc(tbl[8], 64'h400), 1'b0);
        drive(at_pc(tbl[9], 64'h404), 1'b0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {127'b0, bus.out_valid}, 128'd0);
        chk("midrst_extop", {125'b0, bus.out_extOP}, 128'd7);
        chk("midrst_in_ready", {127'b0, bus.in_ready}, 128'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drive(at_pc(tbl[10], 64'h500), 1'b1);

        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", q.size(), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- IF/ID pipeline stage of the RV64I core.
- Accepts fetched instruction words from the fetch unit over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Classifies the opcode into the 3-bit immediate-format select (extOP) consumed by the immediate generator.
- Presents instruction, PC, extOP, register indices and an illegal flag to the execute stage, again over valid/ready.

Parameters:
- PC_W, 64, width of the program counter carried with each instruction.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered instructions (branch/jump redirect)
- in_valid  input  1  fetch presents a word
- in_ready  output  1  stage can accept a word this cycle
- in_instr  input  32  fetched instruction
- in_pc  input  PC_W  PC of in_instr
- out_valid  output  1  decoded instruction available
- out_ready  input  1  execute stage consumes this cycle
- out_instr  output  32  instruction word, to immediate generator instr
- out_pc  output  PC_W  PC of out_instr
- out_extOP  output  3  immediate format select, to immediate generator extOP
- out_rs1  output  5  instr[19:15]
- out_rs2  output  5  instr[24:20]
- out_rd  output  5  instr[11:7]
- out_illegal  output  1  opcode not in supported set

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: main_valid=0, skid_valid=0.
  - out_valid=0; all data outputs 0; out_extOP=3'b111; out_illegal=0.
  - in_ready=1 the cycle after reset deasserts.
- Storage: main entry drives outputs; skid entry holds one overflow word.
- Each entry stores instr, pc, extOP and illegal. Decode is done on the way in, so outputs are pure register outputs.
- in_ready = !skid_valid && !flush. Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Latency: an accepted word appears on out_* the next cycle when the main entry is empty or popping that same cycle.
- Transfer rules, evaluated each cycle (flush has priority):
  - flush=1: main_valid<=0, skid_valid<=0. No word is accepted (in_ready=0). A pop occurring that cycle is still a completed handshake.
  - Main empty, or popping, and skid holds a word: skid moves to main. An accepted word goes to skid; otherwise skid_valid<=0.
  - Main empty, or popping, and skid empty: an accepted word loads main; otherwise main_valid<=0.
  - Main full and not popping: an accepted word loads skid. in_ready is already 0 if skid is full.
- Ordering is strictly FIFO; no word is dropped except by flush.
- out_valid = main_valid. Data outputs hold stable while out_valid=1 and out_ready=0.
- extOP decode from instr[6:0]:
  - 0000011 LOAD, 1100111 JALR, 0001111 MISC-MEM, 1110011 SYSTEM -> 000
  - 0010011 OP-IMM and 0011011 OP-IMM-32 -> 000, except funct3 001/101 (shifts) -> 101
  - 0110111 LUI, 0010111 AUIPC -> 001
  - 0100011 STORE -> 010
  - 1100011 BRANCH -> 011
  - 1101111 JAL -> 100
  - 0110011 OP, 0111011 OP-32 -> 111
  - any other opcode -> 111 with illegal=1
- extOP 110 is never produced.
- Register index fields are sliced unconditionally, whatever the format.
- Reset in the middle of a backpressure stall clears both entries; the word held in skid is lost by design.

Test Plan:
- Streaming: out_ready=1 constantly; feed 4 words back to back: addi 0x00500093 pc 0x0, lui 0x123450B7, sw 0x00112023, jal 0x008000EF. Required: outputs one cycle later in order, extOP 000/001/010/100, in_ready never drops.
- Backpressure: out_ready=0; feed beq 0x00208463 then add 0x002081B3. Required: main=beq (extOP 011), skid=add, in_ready=0 on the third cycle. Raise out_ready: add follows beq, extOP 111, in_ready returns to 1.
- Shift decode: srai 0x4030D093 -> extOP 101, rd=1, rs1=1. addiw 0x0010809B -> extOP 000. Illegal word 0x0000007F -> extOP 111, out_illegal=1.
- Flush with both entries full: assert flush one cycle. Required: in_ready=0 during the flush cycle, out_valid=0 the next cycle, the next accepted word is output first.
- Simultaneous pop+accept with skid full: skid word moves to main, the new word lands in skid, no loss, order preserved.
- Reset mid-stall: reset asserted with both entries full. Required: out_valid=0, out_extOP=111, in_ready=1 the cycle after reset drops.
